// File: rtl/multicycle_control_fsm_if.sv
// Memory handshake bundle between the multi-cycle control sequencer and the
// unified instruction/data memory. The sequencer is the master side.
interface multicycle_control_fsm_if;
    logic mem_req;    // request is live this cycle
    logic mem_write;  // write strobe, meaningful only while mem_req is high
    logic adr_src;    // address select: 0 = PC, 1 = ALUOut
    logic mem_ready;  // memory completes the current request this cycle

    modport master (
        output mem_req,
        output mem_write,
        output adr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  adr_src,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multi-cycle RV32I core. Walks the shared
// datapath through fetch/decode/execute/memory/writeback, decodes ALU control,
// runs the memory req/ready handshake, counts retired instructions and traps
// (sticky) on an illegal opcode.
module multicycle_control_fsm #(
    parameter int CNT_W = 32,
    parameter int ALU_W = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [6:0]                  op,
    input  logic [2:0]                  funct3,
    input  logic                        funct7b5,
    input  logic                        zero,
    multicycle_control_fsm_if.master    mem_bus,
    output logic                        ir_write,
    output logic                        pc_write,
    output logic                        reg_write,
    output logic [1:0]                  result_src,
    output logic [1:0]                  alu_src_a,
    output logic [1:0]                  alu_src_b,
    output logic [ALU_W-1:0]            alu_ctrl,
    output logic                        halted,
    output logic [CNT_W-1:0]            instr_count
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [ALU_W-1:0] ALU_ADD   = ALU_W'(4'b0000);
    localparam logic [ALU_W-1:0] ALU_SUB   = ALU_W'(4'b0001);
    localparam logic [ALU_W-1:0] ALU_AND   = ALU_W'(4'b0010);
    localparam logic [ALU_W-1:0] ALU_OR    = ALU_W'(4'b0011);
    localparam logic [ALU_W-1:0] ALU_XOR   = ALU_W'(4'b0100);
    localparam logic [ALU_W-1:0] ALU_SLT   = ALU_W'(4'b0101);
    localparam logic [ALU_W-1:0] ALU_SLL   = ALU_W'(4'b0110);
    localparam logic [ALU_W-1:0] ALU_SRL   = ALU_W'(4'b0111);
    localparam logic [ALU_W-1:0] ALU_SRA   = ALU_W'(4'b1000);
    localparam logic [ALU_W-1:0] ALU_PASSB = ALU_W'(4'b1001);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_LUI      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic             retire_s;
    logic             halted_r;
    logic [CNT_W-1:0] count_r;

    logic             mem_req_s;
    logic             mem_write_s;
    logic             ir_write_s;
    logic             pc_write_s;
    logic             reg_write_s;

    // funct3/funct7b5 to ALU op; immediates only honour funct7b5 for shifts
    function automatic logic [ALU_W-1:0] alu_decode(input logic [2:0] f3,
                                                    input logic       f7b5,
                                                    input logic       is_imm);
        logic [ALU_W-1:0] res;
        case (f3)
            3'b000:  res = (f7b5 && !is_imm) ? ALU_SUB : ALU_ADD;
            3'b001:  res = ALU_SLL;
            3'b010:  res = ALU_SLT;
            3'b011:  res = ALU_ADD;
            3'b100:  res = ALU_XOR;
            3'b101:  res = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  res = ALU_OR;
            3'b111:  res = ALU_AND;
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

    // State register; async reset returns the sequencer to FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and retire detection (any return to FETCH retires)
    always_comb begin
        next_state_s = state_r;
        retire_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                next_state_s = mem_bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
                    OP_RTYPE:          next_state_s = S_EXECR;
                    OP_ITYPE:          next_state_s = S_EXECI;
                    OP_BRANCH:         next_state_s = S_BRANCH;
                    OP_JAL:            next_state_s = S_JAL;
                    OP_LUI:            next_state_s = S_LUI;
                    default:           next_state_s = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LOAD) begin
                    next_state_s = S_MEMREAD;
                end else if (op == OP_STORE) begin
                    next_state_s = S_MEMWRITE;
                end else begin
                    next_state_s = S_TRAP;
                end
            end
            S_MEMREAD: begin
                next_state_s = mem_bus.mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                next_state_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_MEMWRITE: begin
                if (mem_bus.mem_ready) begin
                    next_state_s = S_FETCH;
                    retire_s     = 1'b1;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end
            S_EXECR, S_EXECI, S_LUI, S_JAL: begin
                next_state_s = S_ALUWB;
            end
            S_ALUWB, S_BRANCH: begin
                next_state_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_TRAP: begin
                next_state_s = S_TRAP;
            end
            default: begin
                // unreachable encodings are treated as a fault and trap
                next_state_s = S_TRAP;
            end
        endcase
    end

    // Moore output decode; strobes are forced low while reset is held
    always_comb begin
        mem_req_s   = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_bus.adr_src = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_ctrl    = ALU_ADD;
        case (state_r)
            S_FETCH: begin
                mem_req_s  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_s = mem_bus.mem_ready;
                pc_write_s = mem_bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                mem_req_s       = 1'b1;
                mem_bus.adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_s       = 1'b1;
                mem_write_s     = 1'b1;
                mem_bus.adr_src = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_ctrl  = alu_decode(funct3, funct7b5, 1'b0);
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = alu_decode(funct3, funct7b5, 1'b1);
            end
            S_LUI: begin
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_PASSB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_ctrl  = ALU_SUB;
                case (funct3)
                    3'b000:  pc_write_s = zero;
                    3'b001:  pc_write_s = ~zero;
                    default: pc_write_s = 1'b0;
                endcase
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_s = 1'b1;
            end
            default: begin
                // TRAP and illegal encodings keep every strobe low
            end
        endcase

        if (!reset) begin
            mem_bus.mem_req   = 1'b0;
            mem_bus.mem_write = 1'b0;
            ir_write          = 1'b0;
            pc_write          = 1'b0;
            reg_write         = 1'b0;
        end else begin
            mem_bus.mem_req   = mem_req_s;
            mem_bus.mem_write = mem_write_s;
            ir_write          = ir_write_s;
            pc_write          = pc_write_s;
            reg_write         = reg_write_s;
        end
    end

    // Sticky trap flag, raised together with entry into TRAP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted_r <= 1'b0;
        end else if (next_state_s == S_TRAP) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    // Retired-instruction counter, wraps naturally at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign halted      = halted_r;
    assign instr_count = count_r;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control sequencer for the multi-cycle RV32I core, the successor to the single-cycle processor.
- Steps one shared datapath (ALU, register file, unified instruction/data memory) through the FETCH/DECODE/EXECUTE/MEM/WB states.
- Decodes opcode, funct3 and funct7b5 into ALU control.
- Runs a req/ready handshake with the memory.
- Counts retired instructions and halts on an illegal opcode.

Parameters:
CNT_W, 32, width of the retired-instruction counter
ALU_W, 4, width of alu_ctrl

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset
op  in  7  instruction opcode, from the instruction register
funct3  in  3  instruction funct3
funct7b5  in  1  instruction bit 30
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request
mem_write  out  1  write strobe, valid while mem_req is high
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
ir_write  out  1  load the instruction register and OldPC
pc_write  out  1  load the PC from the result mux
reg_write  out  1  register file write enable
result_src  out  2  result mux select: 00 = ALUOut, 01 = memory data, 10 = ALU result
alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
alu_src_b  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4
alu_ctrl  out  ALU_W  ALU operation
halted  out  1  illegal opcode trapped (sticky)
instr_count  out  CNT_W  instructions retired

Behaviour:
- alu_ctrl encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, PASSB 1001.
- Reset (reset=0, asynchronous): state=FETCH, halted=0, instr_count=0.
  - While reset is low, every strobe is 0: mem_req, mem_write, ir_write, pc_write, reg_write.
- Outputs are Moore decodes of state. Strobes in handshake states are additionally gated by mem_ready.
- An unlisted mux output is 00 and alu_ctrl defaults to ADD.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, ADD, result_src=10.
  - mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
  - mem_ready=0: stay in FETCH, ir_write=0, pc_write=0.
- DECODE: a=01, b=01, ADD (branch/jump target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - anything else -> TRAP
- MEMADR: a=10, b=01, ADD. op=0000011 goes to MEMREAD; op=0100011 goes to MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Stays until mem_ready=1, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH (retire).
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Stays until mem_ready=1, then FETCH (retire).
- EXECR: a=10, b=00, alu_ctrl from funct3/funct7b5, then ALUWB.
  - 000: ADD, or SUB when funct7b5=1
  - 001: SLL
  - 010: SLT
  - 100: XOR
  - 101: SRL, or SRA when funct7b5=1
  - 110: OR
  - 111: AND
  - 011: ADD
- EXECI: a=10, b=01, same decode as EXECR except funct3=000 is always ADD. funct7b5 applies only for funct3=101. Then ALUWB.
- LUI: b=01, PASSB, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH (retire).
- BRANCH: a=10, b=00, SUB, result_src=00.
  - funct3=000 (beq): pc_write = zero.
  - funct3=001 (bne): pc_write = ~zero.
  - Other funct3 values: pc_write=0.
  - Then FETCH (retire).
- JAL: a=01, b=10, ADD, result_src=00, pc_write=1. PC takes the target already in ALUOut; PC+4 is computed into ALUOut. Then ALUWB.
- TRAP: halted=1, all strobes 0, state held until reset.
- Retire: instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. It wraps from all-ones to 0.
- mem_req stays asserted across stall cycles with address selects stable.
- Reset asserted mid-handshake drops mem_req immediately; no partial write strobe may follow.
- Minimum cycles per instruction with mem_ready tied 1: lw 5, sw 4, R/I/LUI 4, branch 3, jal 4.

Test Plan:
- Reset low for 2 cycles, then release with mem_ready=1 -> mem_req=1 in FETCH, all other strobes 0, instr_count=0, halted=0.
- mem_ready=1; op=0110011, funct3=000, funct7b5=1 -> EXECR drives alu_ctrl=0001; ALUWB has reg_write=1; instr_count=1 after 4 cycles.
- lw (op=0000011) with mem_ready low for 3 cycles in MEMREAD -> mem_req and adr_src=1 held for 4 cycles, no reg_write until MEMWB; total 8 cycles.
- beq with zero=1, then bne with zero=1 -> pc_write=1 in the first BRANCH state and 0 in the second; both instructions retire.
- op=1111111 -> TRAP: halted=1, mem_req=0 permanently, instr_count frozen; reset low clears halted.
- Reset pulsed during a MEMWRITE stall -> mem_write and mem_req drop within the same cycle; after release, state is FETCH and instr_count=0.
